pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Generates per-stage stall/flush for PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers from load-use hazards, EXE-stage redirects (branch taken / jump) and multi-cycle data-memory waits.
- Tracks memory waits with a timeout FSM; drives flush_enable_i of the ID/EXE register directly.

Parameters:
- MEM_TIMEOUT, 16, max cycles in MEM_WAIT before err_o is set; counter width $clog2(MEM_TIMEOUT+1).
- REDIRECT_CYCLES, 1, cycles IF/ID stays flushed after a redirect (1..4); extra cycles cover IMEM latency.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-low (`RstEnable = 1'b0)
- id_reg_addr_1_i  in  5  rs1 of instruction in ID
- id_reg_addr_2_i  in  5  rs2 of instruction in ID
- id_uses_rs1_i, id_uses_rs2_i  in  1 each  ID instruction reads rs1/rs2
- ex_MemRead_i  in  1  load in EXE
- ex_reg_dest_i  in  5  rd in EXE
- ex_redirect_i  in  1  branch taken or jump_enable in EXE
- mem_req_i  in  1  MEM stage issues a data access this cycle
- mem_ready_i  in  1  data memory completes access
- stall_pc_o, stall_if_id_o, stall_id_exe_o, stall_exe_mem_o  out  1 each  hold register
- flush_if_id_o, flush_id_exe_o, flush_mem_wb_o  out  1 each  insert bubble
- state_o  out  2  current FSM state (debug)
- err_o  out  1  sticky memory-timeout error

Behaviour:
- States: RUN=0, MEM_WAIT=1, REDIRECT=2, ERROR=3. Outputs are Mealy (state + inputs, same cycle); state/counters registered.
- Reset (rst_i==0 at posedge): state=RUN, wait_cnt=0, redir_cnt=0, err_o=0; all stall/flush outputs 0 while in RUN with idle inputs.
- Load-use (RUN): hz = ex_MemRead_i & ex_reg_dest_i!=0 & ((id_uses_rs1_i & rs1==rd)|(id_uses_rs2_i & rs2==rd)). hz -> stall_pc_o=stall_if_id_o=1, flush_id_exe_o=1 for exactly that cycle; next cycle the load has left EXE so hz clears naturally. Stays RUN.
- Redirect (RUN, ex_redirect_i=1): flush_if_id_o=flush_id_exe_o=1; overrides load-use (stall_* = 0). If REDIRECT_CYCLES>1 -> REDIRECT, redir_cnt=REDIRECT_CYCLES-1; in REDIRECT flush_if_id_o=1, decrement; at 1 -> RUN.
- Memory wait: mem_req_i & ~mem_ready_i in RUN or REDIRECT -> all four stall_* =1, flush_mem_wb_o=1, next state MEM_WAIT, wait_cnt=1. Highest priority: redirect/load-use ignored that cycle (EXE frozen, re-evaluated after). REDIRECT count frozen, resumes via saved flag after wait.
- MEM_WAIT: same outputs; wait_cnt++ each cycle. mem_ready_i=1 -> outputs drop to 0 that cycle, next RUN (or REDIRECT if pending). wait_cnt==MEM_TIMEOUT without ready -> ERROR, err_o=1.
- ERROR: all stall_* =1 permanently; exit only via reset.
- mem_req_i & mem_ready_i same cycle: single-cycle access, no stall.
- Reset mid-MEM_WAIT/REDIRECT: returns to RUN next edge, counters cleared, err_o cleared.
- rd==x0 never causes a stall.

Optional Feature:
- PIPE_CTRL_PERF_EN defined: adds outputs perf_stall_cnt_o[31:0] (cycles with stall_pc_o=1) and perf_flush_cnt_o[31:0] (redirect events); both saturate at 32'hFFFF_FFFF, clear on reset.
- Undefined: ports and counters absent; rest identical.

Decomposition:
- define.v: state encodings (`PcRun, `PcMemWait, `PcRedirect, `PcError), `ZeroSignal, `RegZeroAddr, `RstEnable.
- Sub-module pipe_hazard_det: purely combinational load-use compare producing hz; the FSM stays in pipe_ctrl.

Test Plan:
- Load-use: ex_MemRead_i=1, ex_reg_dest_i=5, id rs1=5 used -> one cycle stall_pc_o=stall_if_id_o=flush_id_exe_o=1, then all 0.
- Redirect vs hazard: ex_redirect_i=1 with hz true -> flush_if_id_o=flush_id_exe_o=1, stall_pc_o=0; REDIRECT_CYCLES=3 -> flush_if_id_o high 3 cycles total.
- Mem wait: mem_req_i=1, mem_ready_i low 4 cycles then high -> stall_* high 4 cycles, state_o=1, low on ready cycle, state_o=0 next.
- Timeout: MEM_TIMEOUT=16, ready never asserted -> err_o=1 at wait_cnt 16, state_o=3, stalls held; rst_i=0 -> all cleared next edge.
- x0 / unused source: ex_reg_dest_i=0 or id_uses_rs2_i=0 with matching rs2 -> no stall.
- PIPE_CTRL_PERF_EN: 3 load-use events + 1 4-cycle mem wait -> perf_stall_cnt_o=7, perf_flush_cnt_o=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding, control-bundle type and constants for pipe_ctrl.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  localparam logic       RST_ENABLE    = 1'b0;
  localparam logic [4:0] REG_ZERO_ADDR = 5'd0;

  // One bit per pipeline-register hold/bubble line, in pipeline order.
  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_exe;
    logic stall_exe_mem;
    logic flush_if_id;
    logic flush_id_exe;
    logic flush_mem_wb;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE      = ctrl_t'(7'b0000000);
  localparam ctrl_t CTRL_LOAD_USE  = ctrl_t'(7'b1100010);
  localparam ctrl_t CTRL_REDIRECT  = ctrl_t'(7'b0000110);
  localparam ctrl_t CTRL_REDIR_CNT = ctrl_t'(7'b0000100);
  localparam ctrl_t CTRL_MEM_WAIT  = ctrl_t'(7'b1111001);
  localparam ctrl_t CTRL_ERROR     = ctrl_t'(7'b1111000);

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Combinational load-use detector: a load in EXE whose rd feeds a source read in ID.
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hz
);

  // x0 is hard-wired zero, so a load targeting it can never create a dependency.
  assign hz = ex_mem_read & (ex_rd != REG_ZERO_ADDR) &
              ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer with memory-wait timeout FSM.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 16,
  parameter int REDIRECT_CYCLES = 1
)
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_reg_addr_1_i,
  input  logic [4:0]  id_reg_addr_2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic        ex_MemRead_i,
  input  logic [4:0]  ex_reg_dest_i,
  input  logic        ex_redirect_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        stall_id_exe_o,
  output logic        stall_exe_mem_o,
  output logic        flush_if_id_o,
  output logic        flush_id_exe_o,
  output logic        flush_mem_wb_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o,
`endif
  output logic [1:0]  state_o,
  output logic        err_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic [2:0]    redir_cnt, redir_cnt_next;
  logic          redir_pend, redir_pend_next;
  logic          err, err_next;
  logic          hz;
  logic          mem_wait;
  ctrl_t         ctrl;

  pipe_hazard_det u_hazard_det (
    .rs1         (id_reg_addr_1_i),
    .rs2         (id_reg_addr_2_i),
    .uses_rs1    (id_uses_rs1_i),
    .uses_rs2    (id_uses_rs2_i),
    .ex_mem_read (ex_MemRead_i),
    .ex_rd       (ex_reg_dest_i),
    .hz          (hz)
  );

  assign mem_wait = mem_req_i & ~mem_ready_i;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_next      = state;
    wait_cnt_next   = wait_cnt;
    redir_cnt_next  = redir_cnt;
    redir_pend_next = redir_pend;
    err_next        = err;
    ctrl            = CTRL_IDLE;
    case (state)
      ST_RUN: begin
        if (mem_wait) begin
          ctrl            = CTRL_MEM_WAIT;
          state_next      = ST_MEM_WAIT;
          wait_cnt_next   = CW'(1);
          redir_pend_next = 1'b0;
        end else if (ex_redirect_i) begin
          ctrl = CTRL_REDIRECT;
          if (REDIRECT_CYCLES > 1) begin
            state_next     = ST_REDIRECT;
            redir_cnt_next = 3'(REDIRECT_CYCLES - 1);
          end
        end else if (hz) begin
          ctrl = CTRL_LOAD_USE;
        end
      end
      ST_REDIRECT: begin
        // A memory wait freezes the remaining flush count; the pending flag resumes it.
        if (mem_wait) begin
          ctrl            = CTRL_MEM_WAIT;
          state_next      = ST_MEM_WAIT;
          wait_cnt_next   = CW'(1);
          redir_pend_next = 1'b1;
        end else begin
          ctrl = CTRL_REDIR_CNT;
          if (redir_cnt <= 3'd1) begin
            state_next     = ST_RUN;
            redir_cnt_next = 3'd0;
          end else begin
            redir_cnt_next = redir_cnt - 3'd1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready_i) begin
          state_next      = redir_pend ? ST_REDIRECT : ST_RUN;
          redir_pend_next = 1'b0;
          wait_cnt_next   = '0;
        end else begin
          ctrl = CTRL_MEM_WAIT;
          if (wait_cnt == CW'(MEM_TIMEOUT)) begin
            state_next = ST_ERROR;
            err_next   = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt + CW'(1);
          end
        end
      end
      default: ctrl = CTRL_ERROR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all of them update together.
    if (rst_i == RST_ENABLE) begin
      state      <= ST_RUN;
      wait_cnt   <= '0;
      redir_cnt  <= 3'd0;
      redir_pend <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      redir_cnt  <= redir_cnt_next;
      redir_pend <= redir_pend_next;
      err        <= err_next;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic redirect_taken;
  assign redirect_taken = (state == ST_RUN) & ~mem_wait & ex_redirect_i;

  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      perf_stall_cnt_o <= '0;
      perf_flush_cnt_o <= '0;
    end else begin
      if (ctrl.stall_pc && (perf_stall_cnt_o != '1))
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (redirect_taken && (perf_flush_cnt_o != '1))
        perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
    end
  end
`else
  // Counters and their ports are absent in this build.
`endif

  assign stall_pc_o      = ctrl.stall_pc;
  assign stall_if_id_o   = ctrl.stall_if_id;
  assign stall_id_exe_o  = ctrl.stall_id_exe;
  assign stall_exe_mem_o = ctrl.stall_exe_mem;
  assign flush_if_id_o   = ctrl.flush_if_id;
  assign flush_id_exe_o  = ctrl.flush_id_exe;
  assign flush_mem_wb_o  = ctrl.flush_mem_wb;
  assign state_o         = state;
  assign err_o           = err;

endmodule
